// File: rtl/wos_run_ctrl.sv
// Run sequencer for the weighted-order-statistics filter: clears the window, streams
// ROM samples through the filter into the result RAM, and steps the readback address.
module wos_run_ctrl #(
    parameter int N           = 101,
    parameter int DATA_BITS   = 8,
    parameter int ADDR_BITS   = 8,
    parameter int NUM_SAMPLES = 255,
    parameter int FILTER_LAT  = 1,
    parameter int RANK_BITS   = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [RANK_BITS-1:0] rank_in_i,
    output logic [ADDR_BITS-1:0] rom_addr_o,
    input  logic [DATA_BITS-1:0] rom_data_i,
    output logic                 flt_clr_o,
    output logic                 flt_en_o,
    output logic [DATA_BITS-1:0] flt_din_o,
    output logic [RANK_BITS-1:0] flt_rank_o,
    input  logic [DATA_BITS-1:0] flt_dout_i,
    output logic                 ram_we_o,
    output logic [ADDR_BITS-1:0] ram_waddr_o,
    output logic [DATA_BITS-1:0] ram_wdata_o,
    input  logic                 step_up_i,
    input  logic                 step_down_i,
    output logic [ADDR_BITS-1:0] rd_addr_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic [RANK_BITS-1:0]   rank_q, rank_d;
    logic [ADDR_BITS-1:0]   rd_q, rd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fetch_v;
    logic                   accept;

    // Stage 0 marks the cycle the ROM word is on rom_data_i; the last stage is the RAM write.
    logic [FILTER_LAT:0]    vld_q;
    logic [ADDR_BITS-1:0]   idx_q [FILTER_LAT+1];

    assign accept = (state_q == IDLE) && start_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rank_d  = rank_q;
        busy_d  = busy_q;
        done_d  = done_q;
        rd_d    = rd_q;
        fetch_v = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rank_d  = rank_in_i;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = FETCH;
            end
            FETCH: begin
                fetch_v = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // Only the final write stage may still be busy when we hand back control.
                if (vld_q[FILTER_LAT-1:0] == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            rd_d = '0;
        end else if (!busy_q && (step_up_i ^ step_down_i)) begin
            rd_d = step_up_i ? rd_q + 1'b1 : rd_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rank_q  <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            for (int s = 0; s <= FILTER_LAT; s++) begin
                idx_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rank_q  <= rank_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= {vld_q[FILTER_LAT-1:0], fetch_v};
            idx_q[0] <= cnt_q;
            for (int s = 1; s <= FILTER_LAT; s++) begin
                idx_q[s] <= idx_q[s-1];
            end
        end
    end

    assign rom_addr_o  = cnt_q;
    assign flt_clr_o   = (state_q == CLEAR);
    assign flt_en_o    = vld_q[0];
    assign flt_din_o   = vld_q[0] ? rom_data_i : '0;
    assign flt_rank_o  = rank_q;
    assign ram_we_o    = vld_q[FILTER_LAT];
    assign ram_waddr_o = vld_q[FILTER_LAT] ? idx_q[FILTER_LAT] : '0;
    assign ram_wdata_o = vld_q[FILTER_LAT] ? flt_dout_i : '0;
    assign rd_addr_o   = rd_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
